// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-word bit positions, the zero register
// and the shadow entry that follows each instruction through EX, MEM and WB.
package pipeline_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int IDCTRL_EXMEMA  = 0;
  localparam int IDCTRL_EXMEMB  = 1;
  localparam int EXCTRL_EXMEMA  = 3;
  localparam int EXCTRL_EXMEMB  = 4;
  localparam int EXCTRL_MEMWBA  = 5;
  localparam int EXCTRL_MEMWBB  = 6;
  localparam int MEMCTRL_MEMWB  = 4;

  typedef struct packed {
    logic [4:0] rW;
    logic       wr;
    logic       load;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '0;

  // Helpers the decoder uses to drop the selects into its control words.
  function automatic logic [7:0] id_ctrl_fwd(input logic ema, input logic emb);
    logic [7:0] v;
    v = '0;
    v[IDCTRL_EXMEMA] = ema;
    v[IDCTRL_EXMEMB] = emb;
    return v;
  endfunction

  function automatic logic [7:0] ex_ctrl_fwd(input logic ema, input logic emb,
                                             input logic mwa, input logic mwb);
    logic [7:0] v;
    v = '0;
    v[EXCTRL_EXMEMA] = ema;
    v[EXCTRL_EXMEMB] = emb;
    v[EXCTRL_MEMWBA] = mwa;
    v[EXCTRL_MEMWBB] = mwb;
    return v;
  endfunction

  function automatic logic [7:0] mem_ctrl_fwd(input logic mwm);
    logic [7:0] v;
    v = '0;
    v[MEMCTRL_MEMWB] = mwm;
    return v;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage hazard interface: decoded ID fields in, stall and forwarding selects out.
interface pipeline_hazard_ctrl_if;
  import pipeline_pkg::*;

  logic [4:0] rS1;
  logic [4:0] rS2;
  logic       useS1;
  logic       useS2;
  logic [4:0] rWId;
  logic       regWrId;
  logic       loadId;
  logic       storeId;
  logic       branchId;
  logic       mulId;

  logic       stall;
  logic       pcWr;
  logic       ifIdWrIn;
  logic       bubble;
  logic       exMemIdA;
  logic       exMemIdB;
  logic       exMemExA;
  logic       exMemExB;
  logic       memWbExA;
  logic       memWbExB;
  logic       memWbMem;
  shadow_t    shadowWb;

  modport master (
    output rS1, rS2, useS1, useS2, rWId, regWrId, loadId, storeId, branchId, mulId,
    input  stall, pcWr, ifIdWrIn, bubble, exMemIdA, exMemIdB, exMemExA, exMemExB,
           memWbExA, memWbExB, memWbMem, shadowWb
  );

  modport slave (
    input  rS1, rS2, useS1, useS2, rWId, regWrId, loadId, storeId, branchId, mulId,
    output stall, pcWr, ifIdWrIn, bubble, exMemIdA, exMemIdB, exMemExA, exMemExB,
           memWbExA, memWbExB, memWbMem, shadowWb
  );
endinterface

// File: rtl/hazard_match.sv
// Hit when a used, non-zero source register is written by the given shadow entry.
module hazard_match
  import pipeline_pkg::*;
(
  input  logic [4:0] src,
  input  logic       use_src,
  input  shadow_t    entry,
  output logic       hit
);
  assign hit = use_src && (src != REG_ZERO) && entry.wr && (entry.rW == src);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: shadow copy of EX/MEM/WB destinations plus the
// multiplier occupancy counter; selects and stalls are combinational from ID.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int              CNT_W    = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

  shadow_t          ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;

  logic [1:0][4:0] src;
  logic [1:0]      src_use;
  logic [1:0]      hit_ex, hit_mem;
  logic [1:0]      fwd_ex_mem, fwd_mem_wb, fwd_id, load_hit;
  logic            load_use, branch_stall, store_fwd, mul_busy, bubble;

  assign src     = {hz.rS2, hz.rS1};
  assign src_use = {hz.useS2, hz.useS1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      hazard_match u_ex  (.src(src[gi]), .use_src(src_use[gi]), .entry(ex_q),  .hit(hit_ex[gi]));
      hazard_match u_mem (.src(src[gi]), .use_src(src_use[gi]), .entry(mem_q), .hit(hit_mem[gi]));
    end
  endgenerate

  always_comb begin
    fwd_ex_mem   = hit_ex & ~{2{ex_q.load}};
    fwd_mem_wb   = hit_mem & ~fwd_ex_mem;
    fwd_id       = hit_mem & {2{hz.branchId & ~mem_q.load}};
    load_hit     = hit_ex & {2{ex_q.load}};
    // Store data alone can wait for the load in MEM, so only rS1 forces a stall.
    load_use     = load_hit[0] | (load_hit[1] & ~hz.storeId);
    store_fwd    = hz.storeId & load_hit[1] & ~load_hit[0];
    branch_stall = hz.branchId & (hit_ex[0] | (hit_mem[0] & mem_q.load));
    mul_busy     = (mul_cnt_q != '0);
    bubble       = load_use | branch_stall;
  end

  assign hz.stall    = bubble | mul_busy;
  assign hz.pcWr     = ~hz.stall;
  assign hz.ifIdWrIn = ~hz.stall;
  assign hz.bubble   = bubble;
  assign hz.exMemIdA = fwd_id[0] & ~bubble;
  assign hz.exMemIdB = fwd_id[1] & ~bubble;
  assign hz.exMemExA = fwd_ex_mem[0] & ~bubble;
  assign hz.exMemExB = fwd_ex_mem[1] & ~bubble;
  assign hz.memWbExA = fwd_mem_wb[0] & ~bubble;
  assign hz.memWbExB = fwd_mem_wb[1] & ~bubble;
  assign hz.memWbMem = store_fwd & ~bubble;
  assign hz.shadowWb = wb_q;

  always_comb begin
    wb_d      = mem_q;
    mem_d     = ex_q;
    ex_d      = ex_q;
    mul_cnt_d = '0;
    if (mul_busy) begin
      // Multiplier still owns EX: hold it and feed an empty slot into MEM.
      mem_d     = SHADOW_EMPTY;
      mul_cnt_d = mul_cnt_q - CNT_W'(1);
    end else if (bubble) begin
      ex_d = SHADOW_EMPTY;
    end else begin
      ex_d = '{rW: hz.rWId, wr: hz.regWrId, load: hz.loadId};
      if (hz.mulId) mul_cnt_d = MUL_LOAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q      <= SHADOW_EMPTY;
      mem_q     <= SHADOW_EMPTY;
      wb_q      <= SHADOW_EMPTY;
      mul_cnt_q <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios followed by random ID traffic, all checked against a
// record-based model of the instructions occupying EX, MEM and WB.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz_if();
  pipeline_hazard_ctrl #(.MUL_LATENCY(LAT)) dut (.clk(clk), .reset(reset), .hz(hz_if));

  typedef struct packed {
    logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rw;  logic wr; logic ld; logic st; logic br; logic mul;
  } id_t;

  typedef struct {
    logic [4:0] rd; logic wr; logic ld; logic mul;
  } rec_t;

  localparam id_t NOP = '0;

  rec_t m_ex, m_mem, m_wb;
  int   ex_age;
  id_t  cur;

  function automatic id_t mk(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                             logic [4:0] rw, logic wr, logic ld, logic st, logic br, logic mul);
    id_t i;
    i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2; i.rw = rw; i.wr = wr;
    i.ld = ld; i.st = st; i.br = br; i.mul = mul;
    return i;
  endfunction

  function automatic logic writes(rec_t r, logic [4:0] s, logic u);
    return u && (s != 5'd0) && r.wr && (r.rd == s);
  endfunction

  // A multiply keeps EX until it has sat there LAT cycles.
  function automatic logic mul_wait();
    return m_ex.mul && (ex_age < LAT);
  endfunction

  // {stall,pcWr,ifIdWrIn,bubble,idA,idB,exA,exB,mwA,mwB,mwMem}
  function automatic logic [10:0] model_vec();
    logic ea, eb, ma, mb, la, lb, lu, br, bub, stl;
    logic exa, exb, mwa, mwb, ida, idb, mm;
    ea  = writes(m_ex,  cur.rs1, cur.u1);
    eb  = writes(m_ex,  cur.rs2, cur.u2);
    ma  = writes(m_mem, cur.rs1, cur.u1);
    mb  = writes(m_mem, cur.rs2, cur.u2);
    la  = ea & m_ex.ld;
    lb  = eb & m_ex.ld;
    lu  = la | (lb & ~cur.st);
    br  = cur.br & (ea | (ma & m_mem.ld));
    bub = lu | br;
    stl = bub | mul_wait();
    exa = ea & ~m_ex.ld;
    exb = eb & ~m_ex.ld;
    mwa = ma & ~exa;
    mwb = mb & ~exb;
    ida = cur.br & ma & ~m_mem.ld;
    idb = cur.br & mb & ~m_mem.ld;
    mm  = cur.st & lb & ~la;
    if (bub) {ida, idb, exa, exb, mwa, mwb, mm} = '0;
    return {stl, ~stl, ~stl, bub, ida, idb, exa, exb, mwa, mwb, mm};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {hz_if.stall, hz_if.pcWr, hz_if.ifIdWrIn, hz_if.bubble,
            hz_if.exMemIdA, hz_if.exMemIdB, hz_if.exMemExA, hz_if.exMemExB,
            hz_if.memWbExA, hz_if.memWbExB, hz_if.memWbMem};
  endfunction

  task automatic model_reset();
    m_ex  = '{default: '0};
    m_mem = '{default: '0};
    m_wb  = '{default: '0};
    ex_age = 0;
  endtask

  task automatic model_clock();
    logic [10:0] v;
    v = model_vec();
    m_wb = m_mem;
    if (mul_wait()) begin
      m_mem = '{default: '0};
      ex_age++;
    end else begin
      m_mem = m_ex;
      if (v[7]) m_ex = '{default: '0};
      else      m_ex = '{rd: cur.rw, wr: cur.wr, ld: cur.ld, mul: cur.mul};
      ex_age = 1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input id_t i);
    cur = i;
    hz_if.rS1 = i.rs1;     hz_if.useS1 = i.u1;
    hz_if.rS2 = i.rs2;     hz_if.useS2 = i.u2;
    hz_if.rWId = i.rw;     hz_if.regWrId = i.wr;
    hz_if.loadId = i.ld;   hz_if.storeId = i.st;
    hz_if.branchId = i.br; hz_if.mulId = i.mul;
  endtask

  task automatic issue(input id_t i, input string tag);
    drive(i);
    #1;
    check({tag, ".vec"}, 16'(dut_vec()), 16'(model_vec()));
    check({tag, ".wb"}, 16'(hz_if.shadowWb), 16'({m_wb.rd, m_wb.wr, m_wb.ld}));
    step_no++;
    $display("step %0d %s id=%h outs=%b model=%b", step_no, tag, i, dut_vec(), model_vec());
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic flush();
    for (int k = 0; k < 4; k++) begin
      issue(NOP, "flush");
      tick();
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check({tag, ".stall"}, 16'(hz_if.stall), 16'd0);
    check({tag, ".wb"}, 16'(hz_if.shadowWb), 16'd0);
    check({tag, ".vec"}, 16'(dut_vec()), 16'(model_vec()));
    $display("step %0d %s reset asserted outs=%b", step_no, tag, dut_vec());
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int   stalls;
    logic issued2;
    id_t  r;

    drive(NOP);
    model_reset();
    #1;
    check("rst.vec", 16'(dut_vec()), 16'b011_0000_0000);
    check("rst.wb", 16'(hz_if.shadowWb), 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ALU forwarding from EX, then from MEM
    issue(mk(1, 1, 2, 1, 3, 1, 0, 0, 0, 0), "add_r3");      tick();
    issue(mk(3, 1, 2, 1, 4, 1, 0, 0, 0, 0), "sub_r3");
    check("alu.exMemExA", 16'(hz_if.exMemExA), 16'd1);
    check("alu.stall", 16'(hz_if.stall), 16'd0);            tick();
    issue(mk(3, 1, 0, 0, 6, 1, 0, 0, 0, 0), "or_r3");
    check("alu.memWbExA", 16'(hz_if.memWbExA), 16'd1);      tick();
    flush();

    // Load-use on rS2, then the store-data exception
    issue(mk(1, 1, 0, 0, 5, 1, 1, 0, 0, 0), "lw_r5");       tick();
    issue(mk(1, 1, 5, 1, 6, 1, 0, 0, 0, 0), "add_r5");
    check("lu.stall", 16'(hz_if.stall), 16'd1);
    check("lu.bubble", 16'(hz_if.bubble), 16'd1);           tick();
    issue(mk(1, 1, 5, 1, 6, 1, 0, 0, 0, 0), "add_r5");
    check("lu.stall2", 16'(hz_if.stall), 16'd0);
    check("lu.memWbExB", 16'(hz_if.memWbExB), 16'd1);       tick();
    flush();
    issue(mk(1, 1, 0, 0, 5, 1, 1, 0, 0, 0), "lw_r5");       tick();
    issue(mk(1, 1, 5, 1, 0, 0, 0, 1, 0, 0), "sw_r5");
    check("sw.memWbMem", 16'(hz_if.memWbMem), 16'd1);
    check("sw.stall", 16'(hz_if.stall), 16'd0);             tick();
    flush();

    // Branch after ALU producer, then after load
    issue(mk(1, 1, 2, 1, 7, 1, 0, 0, 0, 0), "add_r7");      tick();
    issue(mk(7, 1, 0, 0, 0, 0, 0, 0, 1, 0), "beqz_r7");
    check("bra.stall", 16'(hz_if.stall), 16'd1);            tick();
    issue(mk(7, 1, 0, 0, 0, 0, 0, 0, 1, 0), "beqz_r7");
    check("bra.stall2", 16'(hz_if.stall), 16'd0);
    check("bra.exMemIdA", 16'(hz_if.exMemIdA), 16'd1);      tick();
    flush();
    issue(mk(1, 1, 0, 0, 7, 1, 1, 0, 0, 0), "lw_r7");       tick();
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      issue(mk(7, 1, 0, 0, 0, 0, 0, 0, 1, 0), "beqz_ld");
      stalls += int'(hz_if.stall);
      check("brl.exMemIdA", 16'(hz_if.exMemIdA), 16'd0);
      tick();
    end
    check("brl.stalls", 16'(stalls), 16'd2);
    flush();

    // r0 is never a hazard
    issue(mk(1, 1, 2, 1, 0, 1, 0, 0, 0, 0), "add_r0");      tick();
    issue(mk(0, 1, 0, 1, 9, 1, 0, 0, 1, 0), "use_r0");
    check("r0.vec", 16'(dut_vec()), 16'b011_0000_0000);     tick();
    flush();

    // Single multiply
    issue(mk(1, 1, 2, 1, 8, 1, 0, 0, 0, 1), "mul_r8");
    check("mul.issue_stall", 16'(hz_if.stall), 16'd0);      tick();
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      issue(NOP, "mul_wait");
      if (k == 0) check("mul.pcWr", 16'(hz_if.pcWr), 16'd0);
      stalls += int'(hz_if.stall);
      tick();
    end
    check("mul.stalls", 16'(stalls), 16'd2);
    flush();

    // Back-to-back multiplies
    issue(mk(1, 1, 2, 1, 8, 1, 0, 0, 0, 1), "mul_a");       tick();
    stalls  = 0;
    issued2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      issue(issued2 ? NOP : mk(1, 1, 2, 1, 9, 1, 0, 0, 0, 1), "mul_b");
      stalls += int'(hz_if.stall);
      if (!hz_if.stall) issued2 = 1'b1;
      tick();
    end
    check("mul2.stalls", 16'(stalls), 16'd4);
    flush();

    // Reset in the middle of a multiply
    issue(mk(1, 1, 2, 1, 10, 1, 0, 0, 0, 0), "add_r10");    tick();
    issue(mk(1, 1, 2, 1, 9, 1, 0, 0, 0, 1), "mul_r9");      tick();
    issue(NOP, "mul_busy");
    check("rmul.stall", 16'(hz_if.stall), 16'd1);
    do_reset("rmul");
    issue(mk(9, 1, 10, 1, 11, 1, 0, 0, 0, 0), "after_rst");
    check("rmul.vec", 16'(dut_vec()), 16'b011_0000_0000);   tick();
    flush();

    // Random traffic over a small register set to provoke frequent hits
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rnd_rst");
      end else begin
        r.rs1 = 5'($urandom_range(0, 3));  r.u1  = ($urandom_range(0, 5) != 0);
        r.rs2 = 5'($urandom_range(0, 3));  r.u2  = ($urandom_range(0, 2) != 0);
        r.rw  = 5'($urandom_range(0, 3));  r.wr  = ($urandom_range(0, 3) != 0);
        r.ld  = ($urandom_range(0, 3) == 0);
        r.st  = ($urandom_range(0, 4) == 0);
        r.br  = ($urandom_range(0, 4) == 0);
        r.mul = ($urandom_range(0, 7) == 0);
        issue(r, "rnd");
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and forwarding controller for the five-stage pipeline datapath. It tracks the destination register, write-enable and load flags of the instructions in EX, MEM and WB. From these it produces the ID-stage forwarding selects (exMemIdA/B, exMemExA/B, memWbExA/B, memWbMem) that the decoder packs into idCtrl/exCtrl/memCtrl. It also produces the stall, PC/IF-ID write enables and ID/EX bubble, including a countdown for the multi-cycle multiplier.

## Interface
Parameters:
- MUL_LATENCY, 3, cycles the multiplier occupies EX (≥1)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rS1, rS2  in  5  source registers of the instruction in ID
- useS1, useS2  in  1  ID instruction actually reads rS1 / rS2
- rWId  in  5  destination of the ID instruction (after regDst/link muxing)
- regWrId  in  1  ID instruction writes the integer or FP file
- loadId  in  1  ID instruction is a load
- storeId  in  1  ID instruction is a store (rS2 is store data only)
- branchId  in  1  ID instruction compares rS1 in ID (zFlag/nzFlag)
- mulId  in  1  ID instruction is a multiply
- stall  out  1  hold PC and IF/ID this cycle
- pcWr  out  1  ~stall
- ifIdWrIn  out  1  ~stall
- bubble  out  1  zero aluCtrl/exCtrl/memCtrl/wrCtrl/fp controls entering ID/EX
- exMemIdA, exMemIdB  out  1  ID-stage forward from aluResultMem
- exMemExA, exMemExB  out  1  EX forward from MEM next cycle (registered via exCtrl)
- memWbExA, memWbExB  out  1  EX forward from WB next cycle
- memWbMem  out  1  store data forwarded from busW in MEM (registered via memCtrl)

## Operation
- Shadow pipeline: three entries (EX, MEM, WB), each holding rW[4:0], wr, load. Each clock: WB←MEM, MEM←EX, EX←{rWId, regWrId, loadId}, or EX←0 when bubble.
- Register 0 never matches. A match requires use bit, entry wr=1 and equal rW.
- EX-stage selects, computed in ID:
  - exMemExX = match(rSX, EX entry) and not EX.load.
  - memWbExX = match(rSX, MEM entry) and not exMemExX. MEM has priority over WB.
- ID-stage selects (branch compare):
  - exMemIdA = branchId and match(rS1, MEM) and not MEM.load.
  - exMemIdB is defined the same way on rS2.
- Load-use stall: match(rSX, EX) and EX.load. Exception: storeId with the match only on rS2 sets memWbMem=1 and does not stall.
- Branch stall: branchId and rS1 matches EX (any kind), or matches MEM with MEM.load.
- Multiply counter mulCnt (width clog2(MUL_LATENCY+1)):
  - Loaded with MUL_LATENCY-1 when a non-bubbled mulId enters EX.
  - Decrements to 0 otherwise.
  - While mulCnt≠0: stall=1, and the EX entry is held rather than shifted. MEM receives a zero entry and WB continues.
- stall = loadUse | branchStall | (mulCnt≠0). bubble = loadUse | branchStall. The multiply hold freezes ID/EX instead of bubbling.
- All forwarding outputs are forced to 0 when bubble=1.

## Timing
- Selects, stall and bubble are combinational from the ID inputs and the registered shadow state, with no added latency.
- Load-use stall lasts exactly 1 cycle. The next cycle the consumer issues with memWbEx set.
- Branch after ALU producer in EX: 1 stall, then exMemId=1.
- Branch after load: 2 stalls if the load is in EX, 1 if it is in MEM.
- Multiply: MUL_LATENCY-1 stall cycles after issue. Back-to-back multiplies are separated accordingly.
- Simultaneous hazard sources OR together; the counter still decrements during load/branch stalls.
- Reset (asynchronous, any time): shadow entries=0, mulCnt=0. Outputs: stall=0, bubble=0, pcWr=1, ifIdWrIn=1, all selects=0. Operation resumes on the first edge after deassertion.

## Structure
- Shared package pipeline_pkg holds:
  - idCtrl/exCtrl/memCtrl bit-index constants, e.g. EXCTRL_EXMEMA=3, EXCTRL_MEMWBB=6, MEMCTRL_MEMWB=4.
  - The REG_ZERO constant.
  - The shadow-entry struct {rW, wr, load}.
- Sub-module hazard_match: compares a 5-bit source against one shadow entry and outputs a hit. It is instantiated per source per stage.

## Test plan
- ADD r3 in EX, then SUB using rS1=r3 -> exMemExA=1, stall=0. Next cycle r3 in MEM, a new consumer reading r3 -> memWbExA=1.
- LW r5 in EX, ADD rS2=r5 -> stall=1 and bubble=1 for 1 cycle, then memWbExB=1, stall=0. With SW rS2=r5 instead -> memWbMem=1, no stall.
- ADD r7 then BEQZ r7 -> 1 stall, then exMemIdA=1. LW r7 then BEQZ r7 -> 2 stalls, exMemIdA stays 0.
- Writer to r0 followed by a reader of r0 -> all selects 0, no stall.
- MUL with MUL_LATENCY=3 -> stall high for exactly 2 cycles and pcWr low. A second MUL immediately after waits; the total stall is 4 cycles across both.
- Reset asserted mid-multiply with mulCnt=2 -> stall falls immediately and all shadow entries clear. After release, an instruction reading the old destination gets no forwarding.
